// File: rtl/tcm_sched_pkg.sv
// Shared constants, limb helpers and FSM state type for the carry-less
// multiply scheduler and its bit-serial GF(2) engine.
package tcm_sched_pkg;

    localparam int unsigned OP_W      = 224;
    localparam int unsigned RES_W     = 448;
    localparam int unsigned LIMB_W    = 75;
    localparam int unsigned LIMB_OFF0 = 0;
    localparam int unsigned LIMB_OFF1 = 75;
    localparam int unsigned LIMB_OFF2 = 149;
    localparam int unsigned PP_CYCLES = 77;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_ACC,
        ST_RESP
    } sched_state_t;

    // Middle limb is only 74 bits wide and is zero-extended to the engine width.
    function automatic logic [LIMB_W-1:0] limb_sel(input logic [OP_W-1:0] op,
                                                  input logic [1:0]      idx);
        case (idx)
            2'd0:    limb_sel = op[LIMB_OFF1-1:LIMB_OFF0];
            2'd1:    limb_sel = {1'b0, op[LIMB_OFF2-1:LIMB_OFF1]};
            default: limb_sel = op[OP_W-1:LIMB_OFF2];
        endcase
    endfunction

    function automatic int unsigned limb_off(input logic [1:0] idx);
        case (idx)
            2'd0:    limb_off = LIMB_OFF0;
            2'd1:    limb_off = LIMB_OFF1;
            default: limb_off = LIMB_OFF2;
        endcase
    endfunction

endpackage

// File: rtl/tcm_shared_mul_scheduler_gf2_serial_mul.sv
// Bit-serial LIMB_W x LIMB_W carry-less multiplier: one multiplier bit per
// enabled cycle, product complete after LIMB_W enabled cycles.
module gf2_serial_mul
    import tcm_sched_pkg::*;
#(
    parameter int unsigned LIMB_W = tcm_sched_pkg::LIMB_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_en,
    input  logic [LIMB_W-1:0]     i_a,
    input  logic [LIMB_W-1:0]     i_b,
    output logic [2*LIMB_W-2:0]   o_prod,
    output logic                  o_done
);

    localparam int unsigned P_W   = 2 * LIMB_W - 1;
    localparam int unsigned CNT_W = $clog2(LIMB_W);

    logic [P_W-1:0]    r_a;
    logic [LIMB_W-1:0] r_b;
    logic [P_W-1:0]    r_prod;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_last;

    assign w_last = (r_cnt == CNT_W'(LIMB_W - 1));

    // Multiplicand shifts up while multiplier shifts down, so bit 0 of r_b
    // always gates the correctly aligned copy of a.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_a    <= P_W'(i_a);
            r_b    <= i_b;
            r_prod <= '0;
            r_cnt  <= '0;
        end else if (i_en) begin
            if (r_b[0]) begin
                r_prod <= r_prod ^ r_a;
            end
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_prod = r_prod;
    assign o_done = i_en && w_last;

endmodule

// File: rtl/tcm_shared_mul_scheduler.sv
// Round-robin two-requester front end that time-shares one serial GF(2)
// engine over nine limb partial products and accumulates a 448-bit result.
module tcm_shared_mul_scheduler
    import tcm_sched_pkg::*;
#(
    parameter int unsigned OP_W   = tcm_sched_pkg::OP_W,
    parameter int unsigned LIMB_W = tcm_sched_pkg::LIMB_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_i,
    input  logic [OP_W-1:0]      a0_i,
    input  logic [OP_W-1:0]      b0_i,
    input  logic [OP_W-1:0]      a1_i,
    input  logic [OP_W-1:0]      b1_i,
    output logic [1:0]           gnt_o,
    output logic                 busy_o,
    output logic                 resp_valid_o,
    output logic                 resp_id_o,
    output logic [2*OP_W-1:0]    c_o,
    input  logic                 resp_ready_i
);

    localparam int unsigned RW  = 2 * OP_W;
    localparam int unsigned P_W = 2 * LIMB_W - 1;

    sched_state_t      r_state, w_next;
    logic [OP_W-1:0]   r_a, r_b;
    logic              r_id, r_ptr;
    logic [1:0]        r_li, r_lj;
    logic [RW-1:0]     r_acc;

    logic              w_sel, w_accept, w_last_pp;
    logic              w_eng_start, w_eng_en, w_eng_done;
    logic [LIMB_W-1:0] w_la, w_lb;
    logic [P_W-1:0]    w_prod;
    logic [RW-1:0]     w_pp_aligned;

    assign w_last_pp    = (r_li == 2'd2) && (r_lj == 2'd2);
    assign w_la         = limb_sel(r_a, r_li);
    assign w_lb         = limb_sel(r_b, r_lj);
    assign w_pp_aligned = RW'(w_prod) << (limb_off(r_li) + limb_off(r_lj));

    always_comb begin
        w_next      = r_state;
        w_sel       = 1'b0;
        w_accept    = 1'b0;
        gnt_o       = 2'b00;
        w_eng_start = 1'b0;
        w_eng_en    = 1'b0;
        case (req_i)
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = r_ptr;
            default: w_sel = 1'b0;
        endcase
        case (r_state)
            ST_IDLE: begin
                // Reset has priority over a same-cycle acceptance.
                if (req_i != 2'b00 && !rst) begin
                    w_accept = 1'b1;
                    gnt_o    = w_sel ? 2'b10 : 2'b01;
                    w_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_eng_start = 1'b1;
                w_next      = ST_MUL;
            end
            ST_MUL: begin
                w_eng_en = 1'b1;
                if (w_eng_done) begin
                    w_next = ST_ACC;
                end
            end
            ST_ACC: begin
                w_next = w_last_pp ? ST_RESP : ST_LOAD;
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= 1'b0;
            r_ptr   <= 1'b0;
            r_li    <= '0;
            r_lj    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= w_sel ? a1_i : a0_i;
                r_b   <= w_sel ? b1_i : b0_i;
                r_id  <= w_sel;
                r_ptr <= ~w_sel;
                r_li  <= '0;
                r_lj  <= '0;
                r_acc <= '0;
            end else if (r_state == ST_ACC) begin
                r_acc <= r_acc ^ w_pp_aligned;
                if (r_lj == 2'd2) begin
                    r_lj <= '0;
                    r_li <= r_li + 2'd1;
                end else begin
                    r_lj <= r_lj + 2'd1;
                end
            end
        end
    end

    gf2_serial_mul #(
        .LIMB_W (LIMB_W)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_eng_start),
        .i_en    (w_eng_en),
        .i_a     (w_la),
        .i_b     (w_lb),
        .o_prod  (w_prod),
        .o_done  (w_eng_done)
    );

    assign busy_o       = (r_state != ST_IDLE);
    assign resp_valid_o = (r_state == ST_RESP);
    assign resp_id_o    = r_id;
    assign c_o          = r_acc;

endmodule
